// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with programmable wait states.
// Optional misalignment check enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic [3:0]  be,
    output logic        ready,
    output logic [31:0] rd,
    output logic        err
);

    localparam int AW    = DEPTH_LOG2;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT4 = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        w_accept;
    logic        w_enter_done;

    logic          r_we;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_wd;
    logic [3:0]    r_be;
    logic          r_mis;
    logic          r_err;
    logic [31:0]   r_rd;
    logic [31:0]   r_mem [DEPTH];

    logic          w_in_mis;
    logic          w_we;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_wd;
    logic [3:0]    w_be;
    logic          w_mis;
    logic          w_unused_addr;

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_in_mis = |addr[1:0];
`else
    assign w_in_mis = 1'b0;
`endif

    assign w_unused_addr = &{1'b0, addr[31:AW+2], addr[1:0]};

    // With zero latency the access completes on the accepting edge,
    // so the live request fields are used instead of the latched copy.
    always_comb begin
        w_we  = r_we;
        w_idx = r_idx;
        w_wd  = r_wd;
        w_be  = r_be;
        w_mis = r_mis;
        if (r_state == S_IDLE) begin
            w_we  = we;
            w_idx = addr[AW+1:2];
            w_wd  = wd;
            w_be  = be;
            w_mis = w_in_mis;
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_accept     = 1'b0;
        w_enter_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_accept  = 1'b1;
                    w_cnt_nxt = LAT4;
                    if (LATENCY == 0) begin
                        w_state_nxt  = S_DONE;
                        w_enter_done = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt  = S_DONE;
                    w_enter_done = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counter and latched request; reset abandons any access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_wd    <= 32'd0;
            r_be    <= 4'd0;
            r_mis   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_we  <= we;
                r_idx <= addr[AW+1:2];
                r_wd  <= wd;
                r_be  <= be;
                r_mis <= w_in_mis;
            end
            if (w_enter_done) begin
                r_err <= w_mis;
            end
        end
    end

    // Array access happens on the edge entering DONE.
    always_ff @(posedge clk) begin
        if (w_enter_done) begin
            if (w_we && !w_mis) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_be[i]) begin
                        r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
                    end
                end
            end
            r_rd <= (w_we || w_mis) ? 32'd0 : r_mem[w_idx];
        end
    end

    assign ready = (r_state == S_DONE);
    assign rd    = ready ? r_rd : 32'd0;
    assign err   = ready & r_err;

endmodule
